// File: rtl/pool_ctrl.sv
// pool_ctrl: streams one image into the pooling line buffers and fires the pooling unit once per NxN window.
// Latency: buffer write is combinational with the accept; o_func_start one cycle after a window-completing pixel.
// Backpressure: o_ready only in STREAM; i_next_busy parks the FSM in EMIT so the buffers stay frozen on the window.
module pool_ctrl #(
    parameter int input_channels = 16,
    parameter int img_width      = 8,
    parameter int kernel_dim     = 2,
    parameter int datatype_size  = 2
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           i_start,
    input  logic                                           i_valid,
    input  logic [input_channels-1:0][datatype_size-1:0]  i_data,
    output logic                                           o_ready,
    output logic [input_channels-1:0]                      o_ibuf_we,
    output logic [input_channels-1:0][datatype_size-1:0]  o_ibuf_wr_data,
    input  logic                                           i_next_busy,
    output logic                                           o_func_start,
    output logic                                           o_busy,
    output logic                                           o_done
);

    localparam int XW   = (img_width > 1) ? $clog2(img_width) : 1;
    localparam int NWIN = (img_width / kernel_dim) * (img_width / kernel_dim);
    localparam int WW   = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(img_width - 1);
    localparam logic [WW-1:0] W_LAST = WW'(NWIN - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [XW-1:0]   y_q, y_d;
    logic [WW-1:0]   w_q, w_d;
    logic            accept;
    logic            win_end;
    logic            emit_go;

    assign accept  = (state_q == STREAM) && i_valid;
    // The pixel under (x, y) is the bottom-right corner of a window when both phases hit N-1.
    assign win_end = ((int'(x_q) % kernel_dim) == (kernel_dim - 1)) &&
                     ((int'(y_q) % kernel_dim) == (kernel_dim - 1));
    assign emit_go = (state_q == EMIT) && !i_next_busy;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    x_d     = '0;
                    y_d     = '0;
                    w_d     = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        y_d = (y_q == X_LAST) ? '0 : y_q + 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                    if (win_end) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (emit_go) begin
                    w_d     = w_q + 1'b1;
                    state_d = (w_q == W_LAST) ? DONE : STREAM;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
        end
    end

    // Outputs are pure decodes of the registered state, so reset forces them low immediately.
    assign o_ready        = (state_q == STREAM);
    assign o_ibuf_we      = {input_channels{accept}};
    assign o_ibuf_wr_data = i_data;
    assign o_func_start   = emit_go;
    assign o_busy         = (state_q != IDLE);
    assign o_done         = (state_q == DONE);

endmodule

// File: doc/pool_ctrl.md
POOL_CTRL -- requirements
Module: pool_ctrl

Interface
- REQ-001 SHALL have parameter input_channels, default 16: number of channels per pixel.
- REQ-002 SHALL have parameter img_width, default 8: square image width and height, in pixels.
- REQ-003 SHALL have parameter kernel_dim, default 2: window size N (NxN) and stride N; img_width % kernel_dim == 0 is required.
- REQ-004 SHALL have parameter datatype_size, default 2: bits per channel value.
- REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
- REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
- REQ-007 SHALL have port i_start, input, 1 bit: one-cycle pulse that starts one image.
- REQ-008 SHALL have port i_valid, input, 1 bit: upstream pixel present.
- REQ-009 SHALL have port i_data, input, [datatype_size-1:0] x input_channels: the pixel, all channels.
- REQ-010 SHALL have port o_ready, output, 1 bit: pixel accepted this cycle when i_valid is also high.
- REQ-011 SHALL have port o_ibuf_we, output, 1 bit x input_channels: per-channel line-buffer write enable.
- REQ-012 SHALL have port o_ibuf_wr_data, output, [datatype_size-1:0] x input_channels: line-buffer write data.
- REQ-013 SHALL have port i_next_busy, input, 1 bit: the downstream layer cannot take a result.
- REQ-014 SHALL have port o_func_start, output, 1 bit: the pooled window in the line buffers is valid and consumed this cycle.
- REQ-015 SHALL have port o_busy, output, 1 bit: the image is in progress.
- REQ-016 SHALL have port o_done, output, 1 bit: one-cycle pulse when the image is complete.

Function
- REQ-017 SHALL implement the FSM states IDLE, STREAM, EMIT and DONE.
- REQ-018 SHALL hold column counter x and row counter y, each $clog2(img_width) bits, plus window counter w sized for (img_width/kernel_dim)^2.
- REQ-019 In IDLE, an i_start pulse SHALL clear x, y and w and move to STREAM; i_start SHALL be ignored in every other state.
- REQ-020 o_ready SHALL be 1 only in STREAM.
- REQ-021 When a pixel is accepted (i_valid & o_ready), all o_ibuf_we bits SHALL be 1 that same cycle and o_ibuf_wr_data SHALL equal i_data combinationally; otherwise all o_ibuf_we bits SHALL be 0.
- REQ-022 On accept, x SHALL increment; at x == img_width-1, x SHALL wrap to 0 and y SHALL increment.
- REQ-023 An accepted pixel with x%kernel_dim == kernel_dim-1 and y%kernel_dim == kernel_dim-1 completes a window: the next state SHALL be EMIT; any other accept SHALL stay in STREAM.
- REQ-024 In EMIT with i_next_busy == 0, o_func_start SHALL be 1 (combinational) and w SHALL increment; the next state SHALL be DONE if w was the last window, else STREAM.
- REQ-025 In EMIT with i_next_busy == 1, the block SHALL stay in EMIT with o_func_start = 0 and o_ready = 0, so the line buffers do not shift and the window stays intact.
- REQ-026 DONE SHALL last one cycle with o_done = 1, then move to IDLE.
- REQ-027 o_busy SHALL be 1 in STREAM, EMIT and DONE.
- REQ-028 i_valid in any state other than STREAM SHALL write nothing and leave all counters unchanged.
- REQ-029 The first-to-last latency from a window-completing accept to o_func_start SHALL be 1 cycle when i_next_busy == 0.

Reset
- REQ-030 While rst == 0, the block SHALL be forced to state IDLE with x = y = w = 0, asynchronously.
- REQ-031 While rst == 0, o_ready, o_ibuf_we, o_func_start, o_busy and o_done SHALL be 0, and o_ibuf_wr_data SHALL follow i_data.
- REQ-032 A reset asserted mid-image SHALL abandon the image; after release, the block SHALL need a fresh i_start.

Verification
- REQ-033 Basic image, kernel_dim=2, img_width=4, i_next_busy=0, 16 pixels streamed continuously -> o_func_start one cycle after pixel indices 5, 7, 13 and 15; o_done one cycle after the 4th o_func_start; 20 ibuf writes are NOT expected, exactly 16.
- REQ-034 Backpressure, same setup with i_next_busy=1 for 5 cycles after pixel 5 -> o_ready = 0 and no o_ibuf_we for those 5 cycles; o_func_start in the first cycle i_next_busy = 0; the window values are unchanged.
- REQ-035 Gapped input, i_valid toggling 1,0,1,0 -> counters advance only on accepts; the window positions are the same as in REQ-033.
- REQ-036 i_start pulsed during STREAM -> no effect on x, y or w.
- REQ-037 rst dropped after pixel 9 -> outputs go to 0 immediately; after release with i_start, a full image completes with 4 windows.
- REQ-038 kernel_dim=3, img_width=6 -> o_func_start after pixel indices 14, 17, 32 and 35.
